// File: rtl/rx_shift.sv
// rx_shift: reassembles NBYTES bytes (first byte -> MSB) into one block and strobes it downstream.
// Optional RX_TIMEOUT_EN macro drops a partial block after TIMEOUT_CYCLES idle cycles.
`default_nettype none

module rx_shift #(
  parameter int NBYTES         = 16,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TO_W           = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            din,
  input  logic                  rx_done,
  input  logic                  buffer_full,
  output logic                  buffer_write,
  output logic [8*NBYTES-1:0]   dout,
  output logic                  overrun,
  output logic                  timeout,
  output logic                  busy
);

  localparam int DW = 8 * NBYTES;
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_FLUSH   = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   ctr_q, ctr_d;
  logic [DW-1:0]   shreg_q, shreg_d;
  logic [DW-1:0]   dout_q, dout_d;
  logic            write_q, write_d;
  logic            overrun_q, overrun_d;
  logic            timeout_q, timeout_d;
  logic            busy_q, busy_d;

`ifdef RX_TIMEOUT_EN
  localparam logic [TO_W-1:0] IDLE_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] idle_q, idle_d;
`else
  logic [TO_W-1:0] unused_timeout_cfg;
  assign unused_timeout_cfg = TO_W'(TIMEOUT_CYCLES);
`endif

  always_comb begin
    state_d   = state_q;
    ctr_d     = ctr_q;
    shreg_d   = shreg_q;
    dout_d    = dout_q;
    write_d   = 1'b0;
    overrun_d = 1'b0;
    timeout_d = 1'b0;
`ifdef RX_TIMEOUT_EN
    idle_d    = '0;
`endif
    case (state_q)
      S_COLLECT: begin
        if (rx_done) begin
          shreg_d = {shreg_q[DW-9:0], din};
          if (ctr_q == LAST_BYTE) begin
            ctr_d   = '0;
            state_d = S_FLUSH;
          end else begin
            ctr_d = ctr_q + 1'b1;
          end
        end
`ifdef RX_TIMEOUT_EN
        // Idle only counts while a partial block is held; a same-edge byte wins.
        else if (ctr_q != '0) begin
          if (idle_q == IDLE_LAST) begin
            ctr_d     = '0;
            shreg_d   = '0;
            timeout_d = 1'b1;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
`endif
      end
      S_FLUSH: begin
        overrun_d = rx_done;
        if (!buffer_full) begin
          write_d = 1'b1;
          dout_d  = shreg_q;
          state_d = S_COLLECT;
        end
      end
      default: state_d = S_COLLECT;
    endcase
    busy_d = (ctr_d != '0) || (state_d == S_FLUSH);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_COLLECT;
      ctr_q     <= '0;
      shreg_q   <= '0;
      dout_q    <= '0;
      write_q   <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef RX_TIMEOUT_EN
      idle_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ctr_q     <= ctr_d;
      shreg_q   <= shreg_d;
      dout_q    <= dout_d;
      write_q   <= write_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
`ifdef RX_TIMEOUT_EN
      idle_q    <= idle_d;
`endif
    end
  end

  assign buffer_write = write_q;
  assign dout         = dout_q;
  assign overrun      = overrun_q;
  assign timeout      = timeout_q;
  assign busy         = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_rx_shift.sv
// Self-checking bench for rx_shift: block-level reference model plus directed scenarios.
`default_nettype none

module tb_rx_shift;

  localparam int NB  = 16;
  localparam int TOC = 64;

  logic           clk = 1'b0;
  logic           reset;
  logic [7:0]     din;
  logic           rx_done;
  logic           buffer_full;
  logic           buffer_write;
  logic [127:0]   dout;
  logic           overrun;
  logic           timeout;
  logic           busy;

  rx_shift #(.NBYTES(NB), .TIMEOUT_CYCLES(TOC), .TO_W(17)) dut (
    .clk          (clk),
    .reset        (reset),
    .din          (din),
    .rx_done      (rx_done),
    .buffer_full  (buffer_full),
    .buffer_write (buffer_write),
    .dout         (dout),
    .overrun      (overrun),
    .timeout      (timeout),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    else
      passes++;
  endtask

`ifdef RX_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // Reference model: a byte list plus a pending-block flag.
  logic [7:0]   mq[$];
  logic         m_pend;
  logic [127:0] m_blk;
  logic [127:0] m_dout;
  int           m_idle;
  logic         e_write, e_ovr, e_to, e_busy;

  function automatic logic [127:0] pack_bytes();
    logic [127:0] b = '0;
    for (int i = 0; i < NB; i++) b[127-8*i -: 8] = mq[i];
    return b;
  endfunction

  task automatic model_clear();
    mq.delete();
    m_pend = 1'b0; m_blk = '0; m_dout = '0; m_idle = 0;
    e_write = 1'b0; e_ovr = 1'b0; e_to = 1'b0; e_busy = 1'b0;
  endtask

  task automatic model_step();
    e_write = 1'b0; e_ovr = 1'b0; e_to = 1'b0;
    if (m_pend) begin
      m_idle = 0;
      if (rx_done) e_ovr = 1'b1;
      if (!buffer_full) begin
        e_write = 1'b1;
        m_dout  = m_blk;
        m_pend  = 1'b0;
      end
    end else if (rx_done) begin
      mq.push_back(din);
      m_idle = 0;
      if (mq.size() == NB) begin
        m_blk = pack_bytes();
        mq.delete();
        m_pend = 1'b1;
      end
    end else if (TO_EN && mq.size() != 0) begin
      if (m_idle == TOC - 1) begin
        mq.delete();
        m_idle = 0;
        e_to = 1'b1;
      end else begin
        m_idle++;
      end
    end else begin
      m_idle = 0;
    end
    e_busy = (mq.size() != 0) || m_pend;
  endtask

  // Tallies of observed DUT events for the directed scenario checks.
  int           n_writes = 0, n_ovr = 0, n_to = 0;
  logic [127:0] wq[$];

  initial model_clear();

  always begin
    @(posedge clk);
    if (!reset) model_clear();
    else model_step();
    #1;
    chk("buffer_write", {127'b0, buffer_write}, {127'b0, e_write});
    chk("overrun",      {127'b0, overrun},      {127'b0, e_ovr});
    chk("timeout",      {127'b0, timeout},      {127'b0, e_to});
    chk("busy",         {127'b0, busy},         {127'b0, e_busy});
    chk("dout",         dout,                   m_dout);
    if (buffer_write === 1'b1) begin n_writes++; wq.push_back(dout); end
    if (overrun === 1'b1) n_ovr++;
    if (timeout === 1'b1) n_to++;
  end

  // Called on a falling edge; leaves rx_done low again after gap cycles.
  task automatic send(input logic [7:0] b, input int gap);
    din = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int w0, o0, t0;

  initial begin
    reset = 1'b0; din = '0; rx_done = 1'b0; buffer_full = 1'b0;
    idle(3);
    chk("rst_dout", dout, '0);
    chk("rst_busy", {127'b0, busy}, '0);
    chk("rst_write", {127'b0, buffer_write}, '0);
    chk("rst_overrun", {127'b0, overrun}, '0);
    chk("rst_timeout", {127'b0, timeout}, '0);
    reset = 1'b1;
    idle(2);

    // 1: one block, bytes every 4 cycles
    w0 = n_writes;
    for (int i = 0; i < 16; i++) send(8'(i), 4);
    idle(4);
    chk("t1_writes", 128'(n_writes - w0), 128'd1);
    chk("t1_dout", wq[wq.size()-1], 128'h000102030405060708090A0B0C0D0E0F);
    chk("t1_busy", {127'b0, busy}, '0);

    // 2: downstream full, byte arriving during FLUSH is dropped
    w0 = n_writes; o0 = n_ovr;
    buffer_full = 1'b1;
    for (int i = 0; i < 16; i++) send(8'h30 + 8'(i), 2);
    idle(10);
    send(8'h55, 1);
    idle(38);
    chk("t2_no_write", 128'(n_writes - w0), 128'd0);
    chk("t2_busy", {127'b0, busy}, 128'd1);
    chk("t2_overrun", 128'(n_ovr - o0), 128'd1);
    buffer_full = 1'b0;
    idle(4);
    chk("t2_writes", 128'(n_writes - w0), 128'd1);
    chk("t2_dout", wq[wq.size()-1], 128'h303132333435363738393A3B3C3D3E3F);

    // 3: back-to-back blocks, rx_done every 2 cycles
    w0 = n_writes; o0 = n_ovr;
    for (int i = 0; i < 16; i++) send(8'hA0 + 8'(i), 2);
    for (int i = 0; i < 16; i++) send(8'hB0 + 8'(i), 2);
    idle(4);
    chk("t3_writes", 128'(n_writes - w0), 128'd2);
    chk("t3_dout_a", wq[wq.size()-2], 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
    chk("t3_dout_b", wq[wq.size()-1], 128'hB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF);
    chk("t3_overrun", 128'(n_ovr - o0), 128'd0);

    // 3b: byte on the edge leaving FLUSH is dropped, the next one is kept
    w0 = n_writes; o0 = n_ovr;
    for (int i = 0; i < 16; i++) send(8'hD0 + 8'(i), 1);
    send(8'hE0, 1);
    send(8'hE1, 2);
    idle(2);
    chk("t3b_overrun", 128'(n_ovr - o0), 128'd1);
    chk("t3b_writes", 128'(n_writes - w0), 128'd1);
    chk("t3b_busy", {127'b0, busy}, 128'd1);

    // 4: reset in the middle of a block
    for (int i = 0; i < 7; i++) send(8'h70 + 8'(i), 2);
    reset = 1'b0;
    #1;
    chk("t4_rst_dout", dout, '0);
    chk("t4_rst_busy", {127'b0, busy}, '0);
    @(negedge clk);
    reset = 1'b1;
    idle(2);
    w0 = n_writes;
    for (int i = 0; i < 16; i++) send(8'h10 + 8'(i), 3);
    idle(3);
    chk("t4_writes", 128'(n_writes - w0), 128'd1);
    chk("t4_dout", wq[wq.size()-1], 128'h101112131415161718191A1B1C1D1E1F);

    // 5/6: partial block followed by a long idle gap
    w0 = n_writes; t0 = n_to;
    for (int i = 0; i < 4; i++) send(8'hC0 + 8'(i), 2);
    send(8'hC4, 70);
    chk("t56_timeouts", 128'(n_to - t0), TO_EN ? 128'd1 : 128'd0);
    chk("t56_busy_gap", {127'b0, busy}, TO_EN ? 128'd0 : 128'd1);
    for (int i = 0; i < 16; i++) send(8'h20 + 8'(i), 2);
    idle(3);
    chk("t56_writes", 128'(n_writes - w0), 128'd1);
    if (TO_EN) begin
      chk("t5_dout", dout, 128'h202122232425262728292A2B2C2D2E2F);
      chk("t5_busy", {127'b0, busy}, 128'd0);
    end else begin
      chk("t6_dout", dout, 128'hC0C1C2C3C4202122232425262728292A);
      chk("t6_busy", {127'b0, busy}, 128'd1);
    end

    idle(2);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
